// File: rtl/led_seq_ctrl_if.sv
// rtl/led_seq_ctrl_if.sv - command valid/ready channel from the UART decoder to the LED sequencer
interface led_seq_ctrl_if #(
  parameter int W = 16
) ();
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [W-1:0] cmd_data;

  modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);
endinterface

// File: rtl/led_seq_ctrl.sv
// rtl/led_seq_ctrl.sv - command-driven LED bank sequencer (static/rotate/bounce/blink, programmable step period)
module led_seq_ctrl #(
  parameter int W         = 16,
  parameter int TICK_DIV  = 5000000,
  parameter int DIV_SHIFT = 8,
  parameter int DIV_W     = 32
) (
  input  logic            clk,
  input  logic            rst,
  led_seq_ctrl_if.slave   cmd,
  output logic [W-1:0]    led,
  output logic [2:0]      mode,
  output logic            tick
);

  typedef enum logic {ST_RUN, ST_APPLY} state_t;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_LOAD   = 3'd1;
  localparam logic [2:0] OP_ROTL   = 3'd2;
  localparam logic [2:0] OP_ROTR   = 3'd3;
  localparam logic [2:0] OP_BOUNCE = 3'd4;
  localparam logic [2:0] OP_BLINK  = 3'd5;
  localparam logic [2:0] OP_SETDIV = 3'd6;
  localparam logic [2:0] OP_STOP   = 3'd7;

  localparam logic [2:0] M_STATIC  = 3'd1;
  localparam logic [2:0] M_ROTL    = 3'd2;
  localparam logic [2:0] M_ROTR    = 3'd3;
  localparam logic [2:0] M_BOUNCE  = 3'd4;
  localparam logic [2:0] M_BLINK   = 3'd5;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  state_t           state_q, state_d;
  logic [W-1:0]     led_q, led_d;
  logic [W-1:0]     pat_q, pat_d;
  logic [W-1:0]     data_q, data_d;
  logic [2:0]       mode_q, mode_d;
  logic [2:0]       op_q, op_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             ph_q, ph_d;

  logic             run;
  logic             wrap;
  logic [DIV_W-1:0] period;
  logic [W-1:0]     seed;

  always_comb begin
    run    = (state_q == ST_RUN);
    period = (div_q == '0) ? DIV_W'(1) : div_q;
    // >= rather than == so a period lowered mid-count wraps at once
    wrap   = (cnt_q >= period - DIV_W'(1));
    seed   = (data_q == '0) ? W'(1) : data_q;

    state_d = state_q;
    led_d   = led_q;
    pat_d   = pat_q;
    data_d  = data_q;
    mode_d  = mode_q;
    op_d    = op_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    ph_d    = ph_q;

    if (run) begin
      cnt_d = wrap ? '0 : cnt_q + DIV_W'(1);
      if (wrap) begin
        case (mode_q)
          M_ROTL: led_d = {led_q[W-2:0], led_q[W-1]};
          M_ROTR: led_d = {led_q[0], led_q[W-1:1]};
          M_BOUNCE: begin
            if (dir_q == DIR_LEFT) begin
              if (led_q[W-1]) begin
                dir_d = DIR_RIGHT;
                led_d = led_q >> 1;
              end else begin
                led_d = led_q << 1;
              end
            end else begin
              if (led_q[0]) begin
                dir_d = DIR_LEFT;
                led_d = led_q << 1;
              end else begin
                led_d = led_q >> 1;
              end
            end
          end
          M_BLINK: begin
            ph_d  = ~ph_q;
            led_d = ph_q ? pat_q : '0;
          end
          default: ;
        endcase
      end
      if (cmd.cmd_valid) begin
        state_d = ST_APPLY;
        op_d    = cmd.cmd_op;
        data_d  = cmd.cmd_data;
      end
    end else begin
      state_d = ST_RUN;
      if (op_q != OP_NOP) cnt_d = '0;
      case (op_q)
        OP_LOAD: begin
          pat_d  = data_q;
          led_d  = data_q;
          mode_d = M_STATIC;
        end
        OP_ROTL: begin
          pat_d  = seed;
          led_d  = seed;
          mode_d = M_ROTL;
        end
        OP_ROTR: begin
          pat_d  = seed;
          led_d  = seed;
          mode_d = M_ROTR;
        end
        OP_BOUNCE: begin
          pat_d  = seed;
          led_d  = seed;
          mode_d = M_BOUNCE;
          dir_d  = DIR_LEFT;
        end
        OP_BLINK: begin
          pat_d  = data_q;
          led_d  = data_q;
          ph_d   = 1'b0;
          mode_d = M_BLINK;
        end
        OP_SETDIV: div_d = DIV_W'(data_q) << DIV_SHIFT;
        OP_STOP: begin
          mode_d = M_STATIC;
          pat_d  = led_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      led_q   <= W'(1);
      pat_q   <= W'(1);
      data_q  <= '0;
      mode_q  <= M_ROTL;
      op_q    <= OP_NOP;
      div_q   <= DIV_W'(TICK_DIV);
      cnt_q   <= '0;
      dir_q   <= DIR_LEFT;
      ph_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      pat_q   <= pat_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      op_q    <= op_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      ph_q    <= ph_d;
    end
  end

  assign cmd.cmd_ready = run;
  assign tick          = run && wrap && rst;
  assign led           = led_q;
  assign mode          = mode_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb/tb_led_seq_ctrl.sv - directed scoreboard bench for led_seq_ctrl (TICK_DIV=4, DIV_SHIFT=0)
module tb_led_seq_ctrl;
  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic [W-1:0] led;
  logic [2:0]   mode;
  logic         tick;

  int           n_assert;
  int           n_fail;
  logic [W-1:0] exp_q[$];

  led_seq_ctrl_if #(.W(W)) cmd_if ();

  led_seq_ctrl #(
    .W(W), .TICK_DIV(4), .DIV_SHIFT(0), .DIV_W(32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .cmd (cmd_if.slave),
    .led (led),
    .mode(mode),
    .tick(tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Wait (bounded) for the next tick, then pop the expected post-step LED value.
  task automatic step_chk(input string tag, input int exp_gap);
    int           n;
    logic [W-1:0] e;
    n = 0;
    while (!tick && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_tick"}, 32'(tick), 32'd1);
    if (exp_gap >= 0) chk({tag, "_gap"}, 32'(n), 32'(exp_gap));
    @(negedge clk);
    e = exp_q.pop_front();
    chk({tag, "_led"}, 32'(led), 32'(e));
  endtask

  // Issue one command from a RUN-state negedge; returns at the negedge after APPLY.
  task automatic send(input logic [2:0] op, input logic [W-1:0] data);
    chk("send_ready", 32'(cmd_if.cmd_ready), 32'd1);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_data  = data;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n;
    int ticks;
    logic [W-1:0] v;
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 3'd0;
    cmd_if.cmd_data  = '0;
    repeat (2) @(negedge clk);
    chk("rst_led", 32'(led), 32'h0001);
    chk("rst_mode", 32'(mode), 32'd2);
    chk("rst_ready", 32'(cmd_if.cmd_ready), 32'd1);
    chk("rst_tick", 32'(tick), 32'd0);
    rst = 1'b1;

    // 1: free-running rotate-left, one tick every 4 cycles, wraps at bit 15
    v = 16'h0001;
    for (int i = 0; i < 16; i++) begin
      v = {v[14:0], v[15]};
      exp_q.push_back(v);
    end
    for (int i = 0; i < 16; i++) step_chk("rotl_walk", 3);

    // 2: valid held through APPLY; second command must not be taken there
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = 3'd3;
    cmd_if.cmd_data  = 16'h0003;
    @(negedge clk);
    chk("hs_ready_apply", 32'(cmd_if.cmd_ready), 32'd0);
    chk("hs_tick_apply", 32'(tick), 32'd0);
    cmd_if.cmd_op   = 3'd1;
    cmd_if.cmd_data = 16'hBEEF;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    chk("hs_ready_back", 32'(cmd_if.cmd_ready), 32'd1);
    chk("hs_led", 32'(led), 32'h0003);
    chk("hs_mode", 32'(mode), 32'd3);
    @(negedge clk);
    chk("hs_no_second", 32'(led), 32'h0003);
    exp_q.push_back(16'h8001);
    step_chk("rotr_first", 2);

    // 3: bounce from 0x4000 through both turnarounds
    send(3'd4, 16'h4000);
    chk("bnc_led", 32'(led), 32'h4000);
    chk("bnc_mode", 32'(mode), 32'd4);
    exp_q.push_back(16'h8000);
    v = 16'h4000;
    for (int i = 0; i < 15; i++) begin
      exp_q.push_back(v);
      v = v >> 1;
    end
    exp_q.push_back(16'h0002);
    for (int i = 0; i < 17; i++) step_chk("bounce", 3);
    send(3'd4, 16'h0000);
    chk("bnc_zero_led", 32'(led), 32'h0001);
    exp_q.push_back(16'h0002);
    step_chk("bnc_zero_step", 3);

    // 4: period 0 behaves as 1; blink alternates every cycle starting dark
    send(3'd6, 16'h0000);
    chk("div0_tick", 32'(tick), 32'd1);
    send(3'd5, 16'h00F0);
    chk("blink_led", 32'(led), 32'h00F0);
    chk("blink_mode", 32'(mode), 32'd5);
    for (int i = 0; i < 6; i++) exp_q.push_back((i % 2 == 0) ? 16'h0000 : 16'h00F0);
    for (int i = 0; i < 6; i++) step_chk("blink", 0);

    // 5: STOP freezes the bank while the period counter keeps running
    send(3'd6, 16'h0004);
    send(3'd2, 16'h0010);
    chk("stop_pre_led", 32'(led), 32'h0010);
    send(3'd7, 16'h0000);
    chk("stop_mode", 32'(mode), 32'd1);
    ticks = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (tick) ticks++;
      chk("stop_hold", 32'(led), 32'h0010);
    end
    chk("stop_ticks", 32'(ticks), 32'd6);
    send(3'd1, 16'hA5A5);
    chk("load_led", 32'(led), 32'hA5A5);
    chk("load_mode", 32'(mode), 32'd1);

    // 6: accept on the tick cycle, then reset during APPLY discards the command
    send(3'd2, 16'h0001);
    n = 0;
    while (!tick && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("t6_tick", 32'(tick), 32'd1);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = 3'd1;
    cmd_if.cmd_data  = 16'h1234;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    chk("t6_step_led", 32'(led), 32'h0002);
    chk("t6_apply_ready", 32'(cmd_if.cmd_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("t6_async_led", 32'(led), 32'h0001);
    chk("t6_async_mode", 32'(mode), 32'd2);
    chk("t6_async_ready", 32'(cmd_if.cmd_ready), 32'd1);
    chk("t6_async_tick", 32'(tick), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_discard_led", 32'(led), 32'h0001);
    chk("t6_discard_mode", 32'(mode), 32'd2);
    exp_q.push_back(16'h0002);
    step_chk("t6_resume", 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
